// File: rtl/ga25_pkg.sv
// ga25_pkg: shared types and slot decoding for the GA25 VRAM scheduler.
// Optional byte-enable support is selected with the GA25_VRAM_BE_EN macro.
package ga25_pkg;

  typedef enum logic [1:0] {
    SLOT_IDX,
    SLOT_ATTR,
    SLOT_OBJ,
    SLOT_CPU
  } slot_kind_e;

  // Address distance between consecutive layers' rowscroll/rowselect tables.
  localparam int ROWSCROLL_STRIDE = 'h200;

  typedef struct packed {
    slot_kind_e kind;
    logic [1:0] layer;  // tile layer for SLOT_IDX/SLOT_ATTR
    logic [1:0] word;   // sprite word for SLOT_OBJ
  } slot_t;

  // Map a tick of the round to its owner. Two ticks per slot; slots run
  // L0 idx, L0 attr, ..., L(N-1) attr, obj 0..O-1, CPU.
  function automatic slot_t slot_decode(input int unsigned tick,
                                        input int unsigned num_layers,
                                        input int unsigned obj_words);
    int unsigned slot;
    slot_t       s;
    slot    = tick >> 1;
    s.kind  = SLOT_CPU;
    s.layer = '0;
    s.word  = '0;
    if (slot < 2 * num_layers) begin
      s.kind  = slot[0] ? SLOT_ATTR : SLOT_IDX;
      s.layer = 2'(slot >> 1);
    end else if (slot < 2 * num_layers + obj_words) begin
      s.kind = SLOT_OBJ;
      s.word = 2'(slot - 2 * num_layers);
    end
    return s;
  endfunction

endpackage

// File: rtl/ga25_vram_sched_if.sv
// ga25_vram_sched_if: CPU-side VRAM access bus (level request, busy, read data).
// The cpu_be member exists only when GA25_VRAM_BE_EN is defined.
interface ga25_vram_sched_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              busy;
`ifdef GA25_VRAM_BE_EN
  logic [DATA_W/8-1:0] cpu_be;

  modport master (output cpu_req, cpu_wr, cpu_addr, cpu_din, cpu_be,
                  input  cpu_dout, busy);
  modport slave  (input  cpu_req, cpu_wr, cpu_addr, cpu_din, cpu_be,
                  output cpu_dout, busy);
`else
  modport master (output cpu_req, cpu_wr, cpu_addr, cpu_din,
                  input  cpu_dout, busy);
  modport slave  (input  cpu_req, cpu_wr, cpu_addr, cpu_din,
                  output cpu_dout, busy);
`endif

endinterface

// File: rtl/ga25_cpu_port.sv
// ga25_cpu_port: CPU request edge detect, request latch, busy and read data.
// With GA25_VRAM_BE_EN the byte enables are latched alongside the request.
module ga25_cpu_port
  import ga25_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  ga25_vram_sched_if.slave    cpu,
  input  logic                done,     // capture tick of an issued access
  input  logic [DATA_W-1:0]   q,
  output logic                wr,
  output logic [ADDR_W-1:0]   addr,
`ifdef GA25_VRAM_BE_EN
  output logic [DATA_W/8-1:0] be,
`endif
  output logic [DATA_W-1:0]   din
);

  logic req_q;

  // Accept a new request only on a rising edge of cpu_req while idle;
  // the completing capture has priority and returns read or written data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= 1'b0;
      cpu.busy     <= 1'b0;
      cpu.cpu_dout <= '0;
      wr           <= 1'b0;
      addr         <= '0;
      din          <= '0;
`ifdef GA25_VRAM_BE_EN
      be           <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values,
      // which is what makes req_q a one-clock-delayed copy for the edge detect.
      req_q <= cpu.cpu_req;
      if (done) begin
        cpu.busy     <= 1'b0;
        cpu.cpu_dout <= wr ? din : q;
      end else if (cpu.cpu_req && !req_q && !cpu.busy) begin
        cpu.busy <= 1'b1;
        wr       <= cpu.cpu_wr;
        addr     <= cpu.cpu_addr;
        din      <= cpu.cpu_din;
`ifdef GA25_VRAM_BE_EN
        be       <= cpu.cpu_be;
`endif
      end
    end
  end

endmodule

// File: rtl/ga25_vram_sched.sv
// ga25_vram_sched: fixed-round VRAM slot scheduler for tile layers, sprite
// list and one CPU slot, with a rowscroll/rowselect round after line_start.
// Define GA25_VRAM_BE_EN to enable CPU byte-masked writes.
module ga25_vram_sched
  import ga25_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int OBJ_WORDS  = 3,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int OBJ_BASE   = 'h7700,
  parameter int RS_BASE    = 'h7800,
  parameter int RSEL_BASE  = 'h7c00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  output logic                         ce_pix,
  input  logic                         line_start,
  input  logic [9:0]                   line,
  input  logic [10*NUM_LAYERS-1:0]     y_ofs,
  input  logic [ADDR_W*NUM_LAYERS-1:0] layer_addr,
  output logic [DATA_W*NUM_LAYERS-1:0] layer_idx,
  output logic [DATA_W*NUM_LAYERS-1:0] layer_attr,
  output logic [NUM_LAYERS-1:0]        layer_load,
  output logic [10*NUM_LAYERS-1:0]     rowscroll,
  output logic [10*NUM_LAYERS-1:0]     rowselect,
  output logic [DATA_W-1:0]            obj_word,
  output logic [OBJ_WORDS-1:0]         obj_sel,
  ga25_vram_sched_if.slave             cpu,
  output logic [ADDR_W-1:0]            vram_addr,
  output logic                         vram_we,
  output logic [DATA_W/8-1:0]          vram_be,
  output logic [DATA_W-1:0]            vram_data,
  input  logic [DATA_W-1:0]            vram_q
);

  localparam int                ROUND  = 2 * (2 * NUM_LAYERS + OBJ_WORDS + 1);
  localparam int                TICK_W = $clog2(ROUND);
  localparam logic [TICK_W-1:0] LAST   = TICK_W'(ROUND - 1);

  logic [TICK_W-1:0] tick;        // tick most recently executed
  logic [TICK_W-1:0] tick_n;      // tick executed on the next ce
  slot_t             slot_n;
  logic [ADDR_W-1:0] obj_addr;
  logic              rs_round;
  logic              cpu_issued;  // CPU slot was driven with a pending request
  logic              cpu_done;

  logic              cpu_wr_l;
  logic [ADDR_W-1:0] cpu_addr_l;
  logic [DATA_W-1:0] cpu_din_l;

  logic [9:0]        y_cur;
  logic [ADDR_W-1:0] la_cur;
  logic [ADDR_W-1:0] layer_off;
  logic [8:0]        rs_row;
  logic [ADDR_W-1:0] drive_addr;

  assign tick_n = (tick == LAST) ? '0 : tick + 1'b1;
  assign slot_n = slot_decode(32'(tick_n), NUM_LAYERS, OBJ_WORDS);
  // A ce with the next tick odd is a capture tick; line_start is only honoured there.
  assign ce_pix = ce & ~tick[0];

  assign cpu_done = ce & tick_n[0] & (slot_n.kind == SLOT_CPU) & cpu_issued;

  ga25_cpu_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu_port (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu),
    .done  (cpu_done),
    .q     (vram_q),
    .wr    (cpu_wr_l),
    .addr  (cpu_addr_l),
`ifdef GA25_VRAM_BE_EN
    .be    (vram_be),
`endif
    .din   (cpu_din_l)
  );

`ifndef GA25_VRAM_BE_EN
  assign vram_be = '1;
`endif

  // Address for the slot about to be driven, including rowscroll substitution.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case/if leaves it unassigned, which would infer a latch.
    y_cur      = '0;
    la_cur     = '0;
    drive_addr = cpu_addr_l;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (slot_n.layer == 2'(k)) begin
        y_cur  = y_ofs[k*10 +: 10];
        la_cur = layer_addr[k*ADDR_W +: ADDR_W];
      end
    end
    layer_off = ADDR_W'(32'(slot_n.layer) * ROWSCROLL_STRIDE);
    rs_row    = 9'(y_cur + line);
    case (slot_n.kind)
      SLOT_IDX:  drive_addr = rs_round ? ADDR_W'(RS_BASE) + layer_off + ADDR_W'(rs_row)
                                       : la_cur;
      SLOT_ATTR: drive_addr = rs_round ? ADDR_W'(RSEL_BASE) + layer_off + ADDR_W'(line[7:0])
                                       : la_cur | ADDR_W'(1);
      SLOT_OBJ:  drive_addr = obj_addr;
      default:   drive_addr = cpu_addr_l;
    endcase
  end

  // Slot sequencer: drive on even ticks, capture on odd ticks, restart on line_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick       <= LAST;
      obj_addr   <= ADDR_W'(OBJ_BASE);
      rs_round   <= 1'b0;
      cpu_issued <= 1'b0;
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_data  <= '0;
      layer_idx  <= '0;
      layer_attr <= '0;
      layer_load <= '0;
      rowscroll  <= '0;
      rowselect  <= '0;
      obj_word   <= '0;
      obj_sel    <= '0;
    end else begin
      vram_we <= 1'b0;
      if (ce) begin
        layer_load <= '0;
        obj_sel    <= '0;
        tick       <= tick_n;
        if (!tick_n[0]) begin
          vram_addr <= drive_addr;
          if (slot_n.kind == SLOT_OBJ) obj_addr <= obj_addr + 1'b1;
          if (slot_n.kind == SLOT_CPU) begin
            cpu_issued <= cpu.busy;
            vram_we    <= cpu.busy & cpu_wr_l;
            vram_data  <= cpu_din_l;
          end
        end else begin
          for (int k = 0; k < NUM_LAYERS; k++) begin
            if (slot_n.layer == 2'(k)) begin
              if (slot_n.kind == SLOT_IDX) begin
                if (rs_round) rowscroll[k*10 +: 10] <= vram_q[9:0];
                else          layer_idx[k*DATA_W +: DATA_W] <= vram_q;
              end
              if (slot_n.kind == SLOT_ATTR) begin
                if (rs_round) rowselect[k*10 +: 10] <= vram_q[9:0];
                else begin
                  layer_attr[k*DATA_W +: DATA_W] <= vram_q;
                  layer_load[k]                  <= 1'b1;
                end
              end
            end
          end
          if (slot_n.kind == SLOT_OBJ) begin
            obj_word <= vram_q;
            for (int j = 0; j < OBJ_WORDS; j++) begin
              if (slot_n.word == 2'(j)) obj_sel[j] <= 1'b1;
            end
          end
          if (slot_n.kind == SLOT_CPU) cpu_issued <= 1'b0;
          if (tick_n == LAST) rs_round <= 1'b0;
        end
        if (ce_pix && line_start) begin
          tick     <= LAST;
          obj_addr <= ADDR_W'(OBJ_BASE);
          rs_round <= 1'b1;
        end
      end
    end
  end

endmodule
